sum_accum: RTL and testbench
============================

SUM_ACCUM -- requirements
Module: sum_accum

Interface
REQ-001 Parameter: ADD_LAT, 3, enabled-cycle latency of the fp_add instance; legal range 1..15.
REQ-002 Parameter: CNT_W, 16, width of the sample counter.
REQ-003 Port: clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: clk_en  input  1  global stall; low freezes all state, including the fp_add pipeline.
REQ-006 Port: in_data  input  32  IEEE-754 single-precision sample, i.e. the f(x) result stream from the upstream evaluation pipeline.
REQ-007 Port: in_valid  input  1  in_data and in_last are valid this cycle.
REQ-008 Port: in_last  input  1  marks the final sample of the current vector.
REQ-009 Port: in_ready  output  1  block can accept a sample this cycle.
REQ-010 Port: sum  output  32  fp32 sum of the completed vector.
REQ-011 Port: sum_valid  output  1  one-cycle pulse qualifying sum and count.
REQ-012 Port: count  output  CNT_W  number of samples in the completed vector.
REQ-013 Port: busy  output  1  high whenever state is not IDLE or the accumulator is non-empty.

Function
REQ-014 The block SHALL instantiate one fp_add, with en tied to clk_en and areset tied to reset; all arithmetic SHALL be done by this instance.
REQ-015 States SHALL be IDLE, ADD and DONE; all transitions occur only on edges where clk_en=1.
REQ-016 A sample SHALL be accepted on an edge where clk_en=1, in_valid=1 and in_ready=1; in_ready SHALL be 1 only in IDLE.
REQ-017 On acceptance, the fp_add operand registers SHALL load acc and in_data, in_last SHALL be captured, and state SHALL go IDLE->ADD.
REQ-018 In ADD, a wait counter SHALL count ADD_LAT enabled edges; on the ADD_LAT-th edge, acc SHALL load the fp_add q and the sample count SHALL increment.
REQ-019 On that same edge, state SHALL go to DONE if the captured in_last=1, otherwise to IDLE.
REQ-020 Throughput SHALL be one sample per ADD_LAT+1 enabled cycles.
REQ-021 In DONE, for exactly one cycle: sum_valid=1, sum=acc, count=sample count; at the next enabled edge acc SHALL clear to 32'h00000000, the counter SHALL clear to 0, and state SHALL go to IDLE.
REQ-022 sum and count SHALL hold their last values after the sum_valid pulse; sum_valid=0 in all other states.
REQ-023 If clk_en=0 while in DONE, sum_valid SHALL stay high until the edge at which DONE is exited.
REQ-024 in_valid while in_ready=0 SHALL NOT be consumed; the upstream block holds in_data, in_valid and in_last stable until accepted.
REQ-025 The sample counter SHALL saturate at 2^CNT_W-1; accumulation SHALL continue while saturated.
REQ-026 NaN, Inf and denormal handling SHALL follow the fp_add instance unmodified; no special-case logic is added.

Reset
REQ-027 While reset=1: state=IDLE, acc=0, counter=0, wait counter=0, sum=0, count=0, sum_valid=0, in_ready=0, busy=0.
REQ-028 in_ready SHALL be 1 on the first cycle after reset deasserts.
REQ-029 Reset asserted mid-ADD or mid-DONE SHALL discard the in-flight sample and the partial sum, with no sum_valid pulse.

Verification
REQ-030 ADD_LAT=3, clk_en=1: send 3F800000, 40000000, then 3F000000 with last -> one sum_valid pulse with sum=40600000 and count=3; in_ready is high once every 4 cycles.
REQ-031 Single sample C0400000 with last -> sum=C0400000, count=1; the next vector starts from acc=0.
REQ-032 Hold in_valid=1 continuously with a new value each accepted beat -> every offered value is summed exactly once; no value is dropped or duplicated.
REQ-033 Drop clk_en for 5 cycles mid-ADD and again during DONE -> result is identical to the unstalled run; the sum_valid pulse is stretched over the stalled cycles only.
REQ-034 Assert reset during ADD of the second sample, then send 3F800000 with last -> sum=3F800000, count=1, with no earlier sum_valid pulse.
REQ-035 Force the counter near saturation (CNT_W=2, send 5 samples of 3F800000 with last on the fifth) -> count=3, sum=40A00000.

Source files
------------

// File: rtl/sum_accum.sv
// Sums an fp32 sample stream into one total per vector, using a single pipelined fp_add.
// One sample per ADD_LAT+1 enabled cycles; in_ready is high only while idle, and clk_en low freezes everything.

module fp_add #(
    parameter int LAT = 3
) (
    input  logic        clk,
    input  logic        areset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] q
);
    logic [31:0] op_a, op_b, res;

    // Round-to-nearest-even single-precision add, with denormals handled and NaN quietened.
    function automatic logic [31:0] add_f32(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] big, sml;
        logic [7:0]  eb, es, d;
        logic [23:0] mb, ms;
        logic [26:0] ms_x, ms_sh;
        logic        sticky, found, up, sgn;
        logic [27:0] r;
        logic [9:0]  e;
        logic [4:0]  lz, sh;
        logic [24:0] mr;
        if ((x[30:23] == 8'hFF && x[22:0] != 23'd0) || (y[30:23] == 8'hFF && y[22:0] != 23'd0))
            return 32'h7FC0_0000;
        if (x[30:23] == 8'hFF) begin
            if (y[30:23] == 8'hFF && x[31] != y[31])
                return 32'h7FC0_0000;
            return x;
        end
        if (y[30:23] == 8'hFF)
            return y;
        if (x[30:0] >= y[30:0]) begin
            big = x;
            sml = y;
        end else begin
            big = y;
            sml = x;
        end
        eb = (big[30:23] == 8'd0) ? 8'd1 : big[30:23];
        es = (sml[30:23] == 8'd0) ? 8'd1 : sml[30:23];
        mb = {big[30:23] != 8'd0, big[22:0]};
        ms = {sml[30:23] != 8'd0, sml[22:0]};
        d  = eb - es;
        ms_x = {ms, 3'b000};
        if (d > 8'd26) begin
            ms_sh  = 27'd0;
            sticky = |ms;
        end else begin
            ms_sh  = ms_x >> d;
            sticky = |(ms_x & ((27'd1 << d) - 27'd1));
        end
        ms_sh[0] = ms_sh[0] | sticky;
        if (big[31] == sml[31])
            r = {1'b0, mb, 3'b000} + {1'b0, ms_sh};
        else
            r = {1'b0, mb, 3'b000} - {1'b0, ms_sh};
        if (r == 28'd0)
            return {big[31] & sml[31], 31'd0};
        sgn = big[31];
        e   = {2'b00, eb};
        if (r[27]) begin
            r = {1'b0, r[27:2], r[1] | r[0]};
            e = e + 10'd1;
        end else begin
            lz    = 5'd0;
            found = 1'b0;
            for (int i = 26; i >= 0; i--) begin
                if (!found) begin
                    if (r[i])
                        found = 1'b1;
                    else
                        lz = lz + 5'd1;
                end
            end
            // Never normalise below the minimum exponent: the result stays denormal instead.
            sh = ({5'd0, lz} < e - 10'd1) ? lz : 5'(e - 10'd1);
            r  = r << sh;
            e  = e - {5'd0, sh};
        end
        up = r[2] & (r[1] | r[0] | r[3]);
        mr = {1'b0, r[26:3]} + {24'd0, up};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (e >= 10'd255)
            return {sgn, 8'hFF, 23'd0};
        return {sgn, mr[23] ? e[7:0] : 8'd0, mr[22:0]};
    endfunction

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            op_a <= 32'd0;
            op_b <= 32'd0;
        end else if (en) begin
            op_a <= a;
            op_b <= b;
        end
    end

    assign res = add_f32(op_a, op_b);

    generate
        if (LAT == 1) begin : g_direct
            assign q = res;
        end else begin : g_pipe
            logic [31:0] pipe [LAT-1];
            always_ff @(posedge clk or posedge areset) begin
                if (areset) begin
                    for (int i = 0; i < LAT - 1; i++)
                        pipe[i] <= 32'd0;
                end else if (en) begin
                    pipe[0] <= res;
                    for (int i = 1; i < LAT - 1; i++)
                        pipe[i] <= pipe[i-1];
                end
            end
            assign q = pipe[LAT-2];
        end
    endgenerate
endmodule

module sum_accum #(
    parameter int ADD_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [31:0]      sum,
    output logic             sum_valid,
    output logic [CNT_W-1:0] count,
    output logic             busy
);
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state;
    logic [31:0]      acc;
    logic [31:0]      add_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       wait_cnt;
    logic             last_q;
    logic             accept;
    logic             add_done;

    // The adder's operand registers sample acc/in_data on every enabled edge;
    // the one taken at acceptance is what emerges ADD_LAT edges later.
    fp_add #(.LAT(ADD_LAT)) u_add (
        .clk    (clk),
        .areset (reset),
        .en     (clk_en),
        .a      (acc),
        .b      (in_data),
        .q      (add_q)
    );

    assign in_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE) || (cnt != '0);
    assign accept   = clk_en && in_valid && in_ready;
    assign add_done = (state == ADD) && (wait_cnt == 4'(ADD_LAT - 1));
    assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= 32'd0;
            cnt       <= '0;
            wait_cnt  <= 4'd0;
            last_q    <= 1'b0;
            sum       <= 32'd0;
            count     <= '0;
            sum_valid <= 1'b0;
        end else if (clk_en) begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        last_q   <= in_last;
                        wait_cnt <= 4'd0;
                        state    <= ADD;
                    end
                end
                ADD: begin
                    if (add_done) begin
                        acc      <= add_q;
                        cnt      <= cnt_inc;
                        wait_cnt <= 4'd0;
                        if (last_q) begin
                            sum       <= add_q;
                            count     <= cnt_inc;
                            sum_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                DONE: begin
                    acc       <= 32'd0;
                    cnt       <= '0;
                    sum_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sum_accum.sv
// Randomised and directed checks of sum_accum against an exact quarter-unit integer model.
module tb_sum_accum;
    logic        clk = 1'b0;
    logic        rst, clk_en, in_valid, in_last;
    logic [31:0] in_data;
    logic        in_ready, sum_valid, busy;
    logic [31:0] sum;
    logic [15:0] count;
    logic        in_ready_s, sum_valid_s, busy_s;
    logic [31:0] sum_s;
    logic [1:0]  count_s;
    logic        jitter = 1'b0;

    int  n_tests = 0;
    int  n_fail  = 0;
    time last_acc;

    typedef struct {
        logic [31:0] s;
        logic [15:0] c;
        int          len;
    } res_t;
    res_t res_q[$];
    res_t cur;
    logic prev_v = 1'b0;

    sum_accum #(.ADD_LAT(3), .CNT_W(16)) dut (
        .clk(clk), .reset(rst), .clk_en(clk_en), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .sum(sum), .sum_valid(sum_valid),
        .count(count), .busy(busy)
    );

    sum_accum #(.ADD_LAT(3), .CNT_W(2)) dut_s (
        .clk(clk), .reset(rst), .clk_en(clk_en), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready_s), .sum(sum_s), .sum_valid(sum_valid_s),
        .count(count_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Exact fp32 encoding of v/4 for small integers v.
    function automatic logic [31:0] q2f(input int v);
        logic [31:0] a, m;
        int p;
        if (v == 0) return 32'd0;
        a = (v < 0) ? 32'(-v) : 32'(v);
        p = 0;
        for (int i = 0; i < 32; i++)
            if (a[i]) p = i;
        m = a << (23 - p);
        return {v < 0, 8'(127 + p - 2), m[22:0]};
    endfunction

    // Collects each sum_valid pulse: value at its start, length in cycles.
    always @(negedge clk) begin
        if (sum_valid) begin
            if (!prev_v) begin
                cur.s   = sum;
                cur.c   = count;
                cur.len = 0;
            end
            cur.len++;
        end else if (prev_v) begin
            res_q.push_back(cur);
        end
        prev_v = sum_valid;
    end

    // Random clk_en stalls, changed away from the negedge where the driver samples.
    always @(posedge clk) begin
        #2;
        if (jitter) clk_en = ($urandom_range(0, 3) != 0);
    end

    task automatic send(input logic [31:0] d, input logic l);
        int t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!(in_ready && clk_en) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("send_timeout", 64'd1, 64'd0);
        else begin
            @(posedge clk);
            last_acc = $time;
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [31:0] es, input logic [15:0] ec,
                               input int elen);
        int   t = 0;
        res_t r;
        while (res_q.size() == 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (res_q.size() == 0) chk({tag, "_timeout"}, 64'd0, 64'd1);
        else begin
            r = res_q.pop_front();
            chk({tag, "_sum"}, r.s, es);
            chk({tag, "_count"}, r.c, ec);
            if (elen > 0) chk({tag, "_pulse_len"}, r.len, elen);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        time t0, t1;
        int  n, k, ksum, t;
        rst = 1'b1; clk_en = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_count", count, 0);
        chk("rst_sum_valid", sum_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        #1 chk("rdy_after_rst", in_ready, 1);

        // 1.0 + 2.0 + 0.5 with valid held continuously: one accept every 4 cycles
        send(32'h3F80_0000, 1'b0); t0 = last_acc;
        send(32'h4000_0000, 1'b0); t1 = last_acc;
        chk("gap1", t1 - t0, 40);
        send(32'h3F00_0000, 1'b1);
        chk("gap2", last_acc - t1, 40);
        idle();
        wait_result("vec3", 32'h4060_0000, 16'd3, 1);

        send(32'hC040_0000, 1'b1); idle();
        wait_result("single", 32'hC040_0000, 16'd1, 1);
        send(32'h3F80_0000, 1'b1); idle();
        wait_result("restart", 32'h3F80_0000, 16'd1, 1);

        // Stall 5 cycles in ADD and 5 cycles in DONE
        send(32'h4000_0000, 1'b0);
        @(negedge clk); clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        send(32'h4040_0000, 1'b1); idle();
        t = 0;
        while (!sum_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        clk_en = 1'b0;
        repeat (5) @(negedge clk);
        clk_en = 1'b1;
        wait_result("stall", 32'h40A0_0000, 16'd2, 6);

        // Reset during the second sample's ADD
        send(32'h3F80_0000, 1'b0);
        send(32'h4000_0000, 1'b0);
        @(negedge clk); rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        send(32'h3F80_0000, 1'b1); idle();
        wait_result("midrst", 32'h3F80_0000, 16'd1, 1);
        chk("midrst_no_early_pulse", res_q.size(), 0);

        // Counter saturation on the CNT_W=2 instance
        for (int i = 0; i < 5; i++) send(32'h3F80_0000, i == 4);
        idle();
        wait_result("sat_wide", 32'h40A0_0000, 16'd5, 1);
        chk("sat_count", count_s, 3);
        chk("sat_sum", sum_s, 32'h40A0_0000);

        // Random vectors with random stalls
        jitter = 1'b1;
        for (int v = 0; v < 25; v++) begin
            n = $urandom_range(1, 8);
            ksum = 0;
            for (int j = 0; j < n; j++) begin
                k = int'($urandom_range(0, 2000)) - 1000;
                if (k == 0) k = 1;
                ksum += k;
                send(q2f(k), j == n - 1);
            end
            idle();
            wait_result("rnd", q2f(ksum), 16'(n), 0);
        end
        jitter = 1'b0;
        @(negedge clk);
        clk_en = 1'b1;
        repeat (4) @(negedge clk);
        chk("end_no_extra_pulse", res_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
